toggle_pulse_sender: RTL and testbench

TOGGLE_PULSE_SENDER -- requirements
Module: toggle_pulse_sender

---
 rtl/toggle_pulse_sender.sv | 88 ++++++++
 tb/tb_toggle_pulse_sender.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_sender.sv
// Source-domain half of a toggle handshake: queues single-cycle events and
// launches them one at a time as req toggles, waiting for each ack toggle.
module toggle_pulse_sender #(
   parameter int PENDING_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     pulse_in,
   input  logic                     ack_toggle_in,
   output logic                     req_toggle_out,
   output logic [PENDING_WIDTH-1:0] pending_count,
   output logic                     busy,
   output logic                     overflow
);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   localparam logic [PENDING_WIDTH-1:0] CNT_MAX = '1;

   state_t                   state_q, state_d;
   logic                     req_q, req_d;
   logic [PENDING_WIDTH-1:0] cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic                     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic                     ack_event, launch;

   assign ack_event = s2_q ^ s3_q;
   assign launch    = (state_q == IDLE) && (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      s3_d    = s3_q;
      if (enable) begin
         s1_d  = ack_toggle_in;
         s2_d  = s1_q;
         s3_d  = s2_q;
         ovf_d = 1'b0;
         case (state_q)
            IDLE:     if (launch) state_d = WAIT_ACK;
            WAIT_ACK: if (ack_event) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
         req_d = req_q ^ launch;
         // A pulse and a launch on the same edge cancel, so a full queue
         // only drops the event when nothing is leaving it.
         case ({pulse_in, launch})
            2'b10: begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               else                  ovf_d = 1'b1;
            end
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
      end
   end

   assign req_toggle_out = req_q;
   assign pending_count  = cnt_q;
   assign overflow       = ovf_q;
   assign busy           = (state_q == WAIT_ACK) || (cnt_q != '0);

endmodule

// File: tb/tb_toggle_pulse_sender.sv
// Directed bench for toggle_pulse_sender with a 2-bit queue (max 3 pending).
module tb_toggle_pulse_sender;

   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rst, enable, pulse_in, ack_toggle_in;
   logic          req_toggle_out, busy, overflow;
   logic [PW-1:0] pending_count;

   int n_vec = 0;
   int n_err = 0;

   toggle_pulse_sender #(.PENDING_WIDTH(PW)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .pulse_in      (pulse_in),
      .ack_toggle_in (ack_toggle_in),
      .req_toggle_out(req_toggle_out),
      .pending_count (pending_count),
      .busy          (busy),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input int cnt,
                          input logic bsy, input logic ovf);
      chk({tag, ".req"},   32'(req_toggle_out), 32'(req));
      chk({tag, ".cnt"},   32'(pending_count),  32'(cnt));
      chk({tag, ".busy"},  32'(busy),           32'(bsy));
      chk({tag, ".ovf"},   32'(overflow),       32'(ovf));
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Flip the ack and let it settle through s1/s2/s3 (FSM back in IDLE).
   task automatic do_ack();
      ack_toggle_in = ~ack_toggle_in;
      tick(3);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; pulse_in = 1'b0; ack_toggle_in = 1'b0;
      // reset must act even with enable low
      tick(2);
      chk_all("reset", 1'b0, 0, 1'b0, 1'b0);
      rst = 1'b1; enable = 1'b1;
      tick(2);
      chk_all("post_reset", 1'b0, 0, 1'b0, 1'b0);

      // single event
      pulse_in = 1'b1; tick(); pulse_in = 1'b0;
      chk_all("single.k", 1'b0, 1, 1'b1, 1'b0);
      tick();
      chk_all("single.k1", 1'b1, 0, 1'b1, 1'b0);
      tick(3);
      chk_all("single.wait", 1'b1, 0, 1'b1, 1'b0);
      ack_toggle_in = 1'b1; tick(2);
      chk("single.a1.busy", 32'(busy), 32'd1);
      tick();
      chk_all("single.idle", 1'b1, 0, 1'b0, 1'b0);

      // burst of three
      pulse_in = 1'b1;
      tick(); chk("burst.e1.cnt", 32'(pending_count), 32'd1);
      tick(); chk_all("burst.e2", 1'b0, 1, 1'b1, 1'b0);
      tick(); chk_all("burst.e3", 1'b0, 2, 1'b1, 1'b0);
      pulse_in = 1'b0;
      tick(4); chk_all("burst.hold", 1'b0, 2, 1'b1, 1'b0);
      do_ack(); chk_all("burst.ack1", 1'b0, 2, 1'b1, 1'b0);
      tick();   chk_all("burst.l2", 1'b1, 1, 1'b1, 1'b0);
      tick(3);  chk_all("burst.l2w", 1'b1, 1, 1'b1, 1'b0);
      do_ack(); tick(); chk_all("burst.l3", 1'b0, 0, 1'b1, 1'b0);
      do_ack(); chk_all("burst.done", 1'b0, 0, 1'b0, 1'b0);
      tick(3);  chk_all("burst.quiet", 1'b0, 0, 1'b0, 1'b0);

      // overflow: five pulses into a 3-deep queue, ack held
      pulse_in = 1'b1;
      tick(); chk_all("ovf.e1", 1'b0, 1, 1'b1, 1'b0);
      tick(); chk_all("ovf.e2", 1'b1, 1, 1'b1, 1'b0);
      tick(); chk_all("ovf.e3", 1'b1, 2, 1'b1, 1'b0);
      tick(); chk_all("ovf.e4", 1'b1, 3, 1'b1, 1'b0);
      tick(); chk_all("ovf.e5", 1'b1, 3, 1'b1, 1'b1);
      pulse_in = 1'b0;
      tick(); chk_all("ovf.clr", 1'b1, 3, 1'b1, 1'b0);
      do_ack(); chk_all("ovf.ack1", 1'b1, 3, 1'b1, 1'b0);
      // pulse at max coinciding with a launch: kept, no overflow
      pulse_in = 1'b1; tick(); pulse_in = 1'b0;
      chk_all("ovf.maxlaunch", 1'b0, 3, 1'b1, 1'b0);
      tick(); chk_all("ovf.maxlaunch2", 1'b0, 3, 1'b1, 1'b0);
      do_ack(); tick(); chk_all("ovf.l3", 1'b1, 2, 1'b1, 1'b0);
      do_ack(); tick(); chk_all("ovf.l4", 1'b0, 1, 1'b1, 1'b0);
      do_ack(); tick(); chk_all("ovf.l5", 1'b1, 0, 1'b1, 1'b0);
      do_ack(); chk_all("ovf.done", 1'b1, 0, 1'b0, 1'b0);

      // spurious ack in IDLE with empty queue
      do_ack(); tick(2);
      chk_all("spur", 1'b1, 0, 1'b0, 1'b0);

      // enable gating while waiting with one event queued
      pulse_in = 1'b1; tick(2); pulse_in = 1'b0;
      chk_all("gate.pre", 1'b0, 1, 1'b1, 1'b0);
      begin
         logic ack_save;
         ack_save = ack_toggle_in;
         enable = 1'b0;
         for (int i = 0; i < 10; i++) begin
            pulse_in = ~pulse_in;
            ack_toggle_in = ~ack_toggle_in;
            tick();
            chk_all("gate.hold", 1'b0, 1, 1'b1, 1'b0);
         end
         pulse_in = 1'b0;
         ack_toggle_in = ack_save;
         enable = 1'b1;
      end
      tick(4); chk_all("gate.resume", 1'b0, 1, 1'b1, 1'b0);
      do_ack(); tick(); chk_all("gate.launch", 1'b1, 0, 1'b1, 1'b0);
      do_ack(); chk_all("gate.done", 1'b1, 0, 1'b0, 1'b0);

      // reset mid-handshake with two queued
      pulse_in = 1'b1; tick(3); pulse_in = 1'b0;
      chk_all("rstmid.pre", 1'b0, 2, 1'b1, 1'b0);
      rst = 1'b0; ack_toggle_in = 1'b0; tick(); rst = 1'b1;
      chk_all("rstmid.rst", 1'b0, 0, 1'b0, 1'b0);
      tick(3);
      pulse_in = 1'b1; tick(); pulse_in = 1'b0;
      chk_all("rstmid.p", 1'b0, 1, 1'b1, 1'b0);
      tick(); chk_all("rstmid.l", 1'b1, 0, 1'b1, 1'b0);
      tick(4); chk_all("rstmid.w", 1'b1, 0, 1'b1, 1'b0);
      do_ack(); chk_all("rstmid.done", 1'b1, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
